debug_step_ctrl: RTL
====================

DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

Interface
REQ-001 Parameter: DB_CYC, default 50000, consecutive stable cycles required before a debounced input changes (~12 ms at 4.19 MHz).
REQ-002 clk  input  1  system clock, the 4.19 MHz PLL output.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 step_key_n  input  1  raw step pushbutton, active-low, asynchronous to clk.
REQ-005 run_sw  input  1  raw run switch: 1 = free-run, 0 = halt; asynchronous to clk.
REQ-006 step_cnt  input  8  datapath cycles per step press; 0 is treated as 1.
REQ-007 bp_en  input  1  breakpoint enable.
REQ-008 bp_addr  input  16  breakpoint address.
REQ-009 pc  input  16  current datapath program counter.
REQ-010 cpu_en  output  1  datapath clock enable.
REQ-011 state  output  2  controller state: HALT=00, RUN=01, STEP=10, BREAK=11.
REQ-012 bp_hit  output  1  sticky flag, high while in BREAK.
REQ-013 step_done  output  1  one-cycle pulse when a step burst completes.

Function
REQ-014 Input conditioning: step_key_n and run_sw SHALL each pass a 2-flop synchronizer, then a debouncer.
REQ-015 Debouncer counter: SHALL clear whenever the synchronized input equals the debounced value.
REQ-016 Debouncer update: the debounced value SHALL take the synchronized value after DB_CYC consecutive differing cycles; input-to-output latency is 2+DB_CYC cycles.
REQ-017 A registered one-cycle press pulse SHALL fire when debounced key goes 1->0; release SHALL generate nothing.
REQ-018 bp_match = bp_en AND (pc == bp_addr), combinational.
REQ-019 cpu_en SHALL be combinational: 1 in STEP; 1 in RUN when bp_match=0; 0 otherwise.
REQ-020 HALT: run_db=1 -> RUN (priority); else press -> STEP, loading remain = (step_cnt==0 ? 1 : step_cnt).
REQ-021 RUN: run_db=0 -> HALT (priority, bp_hit stays 0); else bp_match -> BREAK; no datapath cycle executes at the matching pc.
REQ-022 STEP: each cycle cpu_en=1 and remain decrements; a cycle with remain==1 -> HALT with step_done=1 in the next cycle, giving exactly N enabled cycles.
REQ-023 STEP: breakpoints, presses and run_db SHALL be ignored.
REQ-024 BREAK: run_db=0 -> HALT (priority); else press -> STEP with load as REQ-020.
REQ-025 BREAK: bp_hit=1, clearing on exit.
REQ-026 Entering RUN with pc already at bp_addr SHALL enter BREAK immediately with zero enabled cycles; stepping is the way off a breakpoint.
REQ-027 step_cnt SHALL be sampled only at STEP entry; changes mid-burst have no effect.

Reset
REQ-028 Assertion SHALL asynchronously force:
- state=HALT, remain=0, debounce counters 0;
- cpu_en=0, bp_hit=0, step_done=0, press pulse 0;
- key synchronizer/debounced key=1 (released);
- run synchronizer/debounced run=0.
REQ-029 Reset asserted mid-STEP SHALL drop cpu_en in the same cycle and abandon the burst, with no step_done.

Structure
REQ-030 Shared package: enum dbg_state_t (HALT, RUN, STEP, BREAK with REQ-011 encodings) and the DB_CYC default constant.
REQ-031 One sub-module, debouncer (synchronizer + counter, parameterized by DB_CYC and reset value), instantiated twice.
REQ-032 The debounce counter width SHALL be $clog2(DB_CYC+1).

Verification (DB_CYC=4)
REQ-033 Reset release with run_sw=1 held -> cpu_en=0 for 6 cycles, then state=RUN and cpu_en=1.
REQ-034 HALT, step_cnt=3, key held low 20 cycles -> exactly 3 cpu_en cycles, one step_done pulse, state=HALT, no repeat.
REQ-035 HALT, step_cnt=0, single press -> exactly 1 cpu_en cycle.
REQ-036 Breakpoint then step-off:
- RUN, bp_en=1, bp_addr=0x0150, pc stepping 0x014E->0x0150 -> cpu_en=0 in the pc==0x0150 cycle, then BREAK with bp_hit=1;
- press with step_cnt=1 -> 1 enabled cycle, HALT, then RUN.
REQ-037 Key bouncing low 3 cycles, high 1 cycle, repeated 5 times -> no press and state stays HALT; then a 6-cycle low -> exactly one STEP.
REQ-038 Reset asserted in STEP with remain=5 -> cpu_en=0 immediately; after release state=HALT and step_done never pulses.

Source files
------------

// File: rtl/debug_step_ctrl_pkg.sv
// Shared types and constants for the debug step controller.
//   dbg_state_t    : controller state encoding (HALT/RUN/STEP/BREAK)
//   DB_CYC_DEFAULT : default debounce length (~12 ms at 4.19 MHz)
//   step_load()    : burst length loaded on STEP entry (0 treated as 1)
package debug_step_ctrl_pkg;

  localparam int unsigned DB_CYC_DEFAULT = 50000;
  localparam int unsigned STEP_W         = 8;
  localparam int unsigned ADDR_W         = 16;

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } dbg_state_t;

  // A requested count of zero still executes one cycle.
  function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] n);
    return (n == STEP_W'(0)) ? STEP_W'(1) : n;
  endfunction

endpackage

// File: rtl/debug_step_ctrl_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer.
//   clk, rst : clock, asynchronous active-low reset
//   din      : raw asynchronous input
//   dout     : debounced level, changes after DB_CYC consecutive differing cycles
module debug_step_ctrl_debouncer
  import debug_step_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYC  = DB_CYC_DEFAULT,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DB_CYC + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;

  // Counter runs only while the synchronized level disagrees with the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      dout    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      if (sync2_q == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYC - 1)) begin
        dout  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug run/step/breakpoint controller producing a datapath clock enable.
//   clk, rst   : clock, asynchronous active-low reset
//   step_key_n : raw step pushbutton (active-low)
//   run_sw     : raw run switch (1 = free-run)
//   step_cnt   : datapath cycles per step press (0 means 1)
//   bp_en, bp_addr, pc : breakpoint enable/address and current pc
//   cpu_en     : datapath clock enable (combinational)
//   state      : controller state
//   bp_hit     : high while in BREAK
//   step_done  : one-cycle pulse after a step burst completes
module debug_step_ctrl
  import debug_step_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYC = DB_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_key_n,
  input  logic              run_sw,
  input  logic [STEP_W-1:0] step_cnt,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic              step_done
);

  logic              key_db;
  logic              run_db;
  logic              key_db_prev_q;
  logic              press_q;
  logic              bp_match;
  dbg_state_t        state_q;
  dbg_state_t        state_d;
  logic [STEP_W-1:0] remain_q;
  logic [STEP_W-1:0] remain_d;

  debug_step_ctrl_debouncer #(.DB_CYC(DB_CYC), .RST_VAL(1'b1)) u_key_db (
    .clk  (clk),
    .rst  (rst),
    .din  (step_key_n),
    .dout (key_db)
  );

  debug_step_ctrl_debouncer #(.DB_CYC(DB_CYC), .RST_VAL(1'b0)) u_run_db (
    .clk  (clk),
    .rst  (rst),
    .din  (run_sw),
    .dout (run_db)
  );

  // Press pulse on the debounced falling edge only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_db_prev_q <= 1'b1;
      press_q       <= 1'b0;
    end else begin
      key_db_prev_q <= key_db;
      press_q       <= key_db_prev_q & ~key_db;
    end
  end

  // State register plus registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HALT;
      remain_q  <= '0;
      bp_hit    <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      bp_hit    <= (state_d == BREAK);
      step_done <= (state_q == STEP) && (remain_q <= STEP_W'(1));
    end
  end

  // Next-state logic; run switch always wins over a press.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      HALT: begin
        if (run_db) begin
          state_d = RUN;
        end else if (press_q) begin
          state_d  = STEP;
          remain_d = step_load(step_cnt);
        end
      end
      RUN: begin
        if (!run_db) begin
          state_d = HALT;
        end else if (bp_match) begin
          state_d = BREAK;
        end
      end
      STEP: begin
        // Burst runs to completion regardless of other inputs.
        remain_d = remain_q - STEP_W'(1);
        if (remain_q <= STEP_W'(1)) begin
          state_d = HALT;
        end
      end
      BREAK: begin
        if (!run_db) begin
          state_d = HALT;
        end else if (press_q) begin
          state_d  = STEP;
          remain_d = step_load(step_cnt);
        end
      end
      default: state_d = HALT;
    endcase
  end

  // Enable is combinational so the matching pc never gets a datapath cycle.
  always_comb begin
    bp_match = bp_en && (pc == bp_addr);
    cpu_en   = 1'b0;
    case (state_q)
      STEP:    cpu_en = 1'b1;
      RUN:     cpu_en = ~bp_match;
      default: cpu_en = 1'b0;
    endcase
  end

  assign state = state_q;

endmodule
